// File: rtl/pim_pkg.sv
// pim_pkg: shared FSM state encoding and width helpers for the PIM crossbar datapath
package pim_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, LAST, OUT} state_t;
  function automatic int acc_w(input int adc_p, input int act_bits);
    return adc_p + act_bits;
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pim_shift_acc.sv
// pim_shift_acc: sign-extend ADC sample, shift by bit-plane index, accumulate; sync clear. Ports: clk, rst (async active-low), clr, en, din, sh, sum (acc + shifted sample)
module pim_shift_acc import pim_pkg::*; #(
  parameter int ADC_P = 8,
  parameter int ACT_BITS = 4,
  localparam int ACC_W = acc_w(ADC_P, ACT_BITS),
  localparam int BW = idx_w(ACT_BITS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [ADC_P-1:0] din,
  input  logic [BW-1:0]    sh,
  output logic [ACC_W-1:0] sum
);
  logic [ACC_W-1:0] acc;
  assign sum = acc + ({{(ACC_W-ADC_P){din[ADC_P-1]}}, din} << sh);
  always_ff @(posedge clk or negedge rst)
    if (!rst) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= sum;
endmodule

// File: rtl/pim_conv_ctrl.sv
// pim_conv_ctrl: bit-serial crossbar sequencer; ports: clk, rst (async active-low), in_* activation handshake, pim_* crossbar drive/return, out_* column result stream, busy
module pim_conv_ctrl import pim_pkg::*; #(
  parameter int INPUT_SIZE = 64,
  parameter int DEPTH = 6,
  parameter int ADC_P = 8,
  parameter int ACT_BITS = 4,
  parameter int NUM_COLS = 64,
  localparam int ACC_W = acc_w(ADC_P, ACT_BITS),
  localparam int BW = idx_w(ACT_BITS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INPUT_SIZE*ACT_BITS-1:0] in_act,
  output logic                         pim_en,
  output logic [INPUT_SIZE-1:0]        pim_feature,
  output logic [DEPTH-1:0]             pim_addr,
  input  logic [ADC_P-1:0]             pim_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_W-1:0]             out_data,
  output logic [DEPTH-1:0]             out_col,
  output logic                         out_last,
  output logic                         busy
);
  state_t state;
  logic [BW-1:0] b, b_d;
  logic v_d, rdy;
  logic [INPUT_SIZE*ACT_BITS-1:0] act;
  logic [DEPTH-1:0] col;
  logic [ACC_W-1:0] sum;
  function automatic logic [INPUT_SIZE-1:0] plane(input logic [INPUT_SIZE*ACT_BITS-1:0] a, input logic [BW-1:0] k);
    for (int i = 0; i < INPUT_SIZE; i++) plane[i] = a[i*ACT_BITS + int'(k)];
  endfunction
  assign in_ready = rdy;
  assign busy = state != IDLE;
  assign pim_en = state == ISSUE;
  assign pim_addr = col;
  assign pim_feature = pim_en ? plane(act, b) : '0;
  // ADC result lags pim_en by one cycle, so the (valid, bit) tag is delayed to match.
  pim_shift_acc #(.ADC_P(ADC_P), .ACT_BITS(ACT_BITS)) u_acc (
    .clk(clk), .rst(rst), .clr(state == IDLE || state == OUT), .en(v_d),
    .din(pim_out), .sh(b_d), .sum(sum)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      rdy <= 1'b0;
      act <= '0;
      col <= '0;
      b <= '0;
      b_d <= '0;
      v_d <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_col <= '0;
      out_last <= 1'b0;
    end else begin
      v_d <= state == ISSUE;
      b_d <= b;
      case (state)
        IDLE:
          if (in_valid && rdy) begin
            act <= in_act;
            col <= '0;
            b <= '0;
            rdy <= 1'b0;
            state <= ISSUE;
          end else rdy <= 1'b1;
        ISSUE:
          if (b == BW'(ACT_BITS-1)) state <= LAST;
          else b <= b + BW'(1);
        // sum already folds in the final bit-plane being captured this cycle
        LAST: begin
          out_data <= sum;
          out_col <= col;
          out_last <= col == DEPTH'(NUM_COLS-1);
          out_valid <= 1'b1;
          state <= OUT;
        end
        default:
          if (out_ready) begin
            out_valid <= 1'b0;
            if (col == DEPTH'(NUM_COLS-1)) begin
              rdy <= 1'b1;
              state <= IDLE;
            end else begin
              col <= col + DEPTH'(1);
              b <= '0;
              state <= ISSUE;
            end
          end
      endcase
    end
endmodule

// File: tb/tb_pim_conv_ctrl.sv
// tb_pim_conv_ctrl: directed bench with conv stub and column-sum reference model for pim_conv_ctrl
module tb_pim_conv_ctrl;
  logic clk = 0, rst = 0, in_valid = 0, out_ready = 1;
  logic [31:0] in_act = 0;
  logic in_ready, pim_en, out_valid, out_last, busy;
  logic [7:0] pim_feature, pim_out;
  logic [1:0] pim_addr, out_col;
  logic [11:0] out_data;
  int n_chk = 0, n_fail = 0, mode = 2, sbit = 0, cyc = 0;
  int accepts = 0, acc_cyc = 0, last_hs = 0, last_gap = 0, hs = 0;
  bit first_pending = 0;
  logic [11:0] qd[$];
  int qc[$];
  logic [11:0] got[4];

  pim_conv_ctrl #(.INPUT_SIZE(8), .DEPTH(2), .ADC_P(8), .ACT_BITS(4), .NUM_COLS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act),
    .pim_en(pim_en), .pim_feature(pim_feature), .pim_addr(pim_addr), .pim_out(pim_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_col(out_col),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] g, input logic [63:0] e);
    n_chk++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, g, e);
    end
  endtask

  function automatic int stub_val(input int m, input int a, input int bi, input logic [7:0] f);
    if (m == 2) return 3;
    if (m == 3) return f != 0 ? -2 : 0;
    return a * 10 + bi;
  endfunction

  // Column result = sum over bit-planes of stub value scaled by 2**b, modulo 2**12.
  function automatic logic [11:0] model_col(input logic [31:0] a, input int c, input int m);
    int s, e;
    logic [7:0] f;
    s = 0;
    for (int bi = 0; bi < 4; bi++) begin
      for (int i = 0; i < 8; i++) begin
        e = int'((a >> (i * 4)) & 32'hF);
        f[i] = ((e >> bi) & 1) == 1;
      end
      s += stub_val(m, c, bi, f) * (1 << bi);
    end
    return s[11:0];
  endfunction

  // conv stub: one-cycle latency, junk when not enabled so stray captures show up
  always @(posedge clk or negedge rst)
    if (!rst) begin
      pim_out <= 0;
      sbit <= 0;
    end else if (pim_en) begin
      pim_out <= 8'(stub_val(mode, int'(pim_addr), sbit, pim_feature));
      sbit <= sbit + 1;
    end else begin
      pim_out <= 8'h5A;
      sbit <= 0;
    end

  always @(negedge clk) begin
    if (!rst) begin
      check("reset_zero", {in_ready, pim_en, pim_feature, pim_addr, out_valid, out_data, out_col, out_last, busy}, 0);
      qd.delete();
      qc.delete();
      first_pending = 0;
    end else begin
      check("busy", busy, qd.size() != 0);
      if (!pim_en) check("feature_idle", pim_feature, 0);
      if (in_valid && in_ready) begin
        for (int c = 0; c < 4; c++) begin
          qd.push_back(model_col(in_act, c, mode));
          qc.push_back(c);
        end
        accepts++;
        last_gap = cyc - last_hs;
        acc_cyc = cyc;
        first_pending = 1;
      end
      if (out_valid) begin
        if (qd.size() == 0) check("unexpected_valid", out_valid, 0);
        else begin
          check("out_data", out_data, qd[0]);
          check("out_col", out_col, qc[0]);
          check("out_last", out_last, qc[0] == 3);
          if (first_pending) begin
            check("latency", cyc - acc_cyc, 6);
            first_pending = 0;
          end
          if (out_ready) begin
            got[out_col] = out_data;
            hs++;
            last_hs = cyc;
            void'(qd.pop_front());
            void'(qc.pop_front());
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] a);
    bit ok = 0;
    @(posedge clk);
    #1 in_valid = 1;
    in_act = a;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      ok = !busy && qd.size() == 0;
    end
    if (!ok) check("idle_timeout", 0, 1);
  endtask

  initial begin
    int base;
    bit seen;
    logic [11:0] hd;
    logic [1:0] hc;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    check("rdy_before_edge", in_ready, 0);
    @(posedge clk);
    #1 check("rdy_after_edge", in_ready, 1);
    // all-ones activations, stub constant 3 -> 3*15
    mode = 2;
    send(32'hFFFF_FFFF);
    wait_idle();
    for (int c = 0; c < 4; c++) check("all_f_literal", got[c], 12'd45);
    // only MSB plane set, stub -2 on nonzero planes -> -16
    mode = 3;
    send(32'h8888_8888);
    wait_idle();
    for (int c = 0; c < 4; c++) check("msb_literal", got[c], 12'hFF0);
    // backpressure on the first column
    mode = 2;
    out_ready = 0;
    send(32'h1234_5678);
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = out_valid;
    end
    if (!seen) check("stall_wait", 0, 1);
    hd = out_data;
    hc = out_col;
    repeat (10) begin
      @(negedge clk);
      check("hold", {out_valid, out_data, out_col, pim_en}, {1'b1, hd, hc, 1'b0});
    end
    @(posedge clk);
    #1 out_ready = 1;
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    check("issue_after_ready", {pim_en, out_valid, pim_addr}, {1'b1, 1'b0, 2'd1});
    #1 out_ready = 1;
    wait_idle();
    // in_valid held across a full transaction
    base = accepts;
    @(posedge clk);
    #1 in_valid = 1;
    in_act = 32'hA5A5_3C3C;
    for (int i = 0; i < 200 && accepts < base + 2; i++) @(posedge clk);
    #1 in_valid = 0;
    check("accepts", accepts - base, 2);
    check("idle_gap", last_gap, 1);
    wait_idle();
    // reset in the middle of a transaction
    mode = 2;
    send(32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1 rst = 0;
    #1 check("async_reset", {in_ready, pim_en, out_valid, busy}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    check("rdy_release", in_ready, 0);
    @(posedge clk);
    #1 check("rdy_release_edge", in_ready, 1);
    repeat (10) begin
      @(negedge clk);
      check("no_valid_after_reset", out_valid, 0);
    end
    // stub returns addr*10 + bit index
    mode = 6;
    send(32'h1111_1111);
    wait_idle();
    check("addr_col0", got[0], 12'd34);
    check("addr_col1", got[1], 12'd184);
    check("addr_col2", got[2], 12'd334);
    check("addr_col3", got[3], 12'd484);
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
